// File: rtl/elbeth_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake to instruction
// memory and feeds IF/ID, holding data across stalls and discarding stale responses.
module elbeth_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_stall,
  input  logic        ctrl_pc_redirect,
  input  logic [31:0] ctrl_pc_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        imem_error,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic        if_exception,
  output logic        if_stall_req
);

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic        hold_err;

  logic [31:0] target;
  logic [31:0] fetch_instr;

  assign target      = {ctrl_pc_target[31:2], 2'b00};
  assign fetch_instr = imem_error ? 32'h0 : imem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RESET;
      pc         <= RESET_VECTOR;
      imem_addr  <= RESET_VECTOR;
      hold_instr <= 32'h0;
      hold_pc    <= 32'h0;
      hold_err   <= 1'b0;
    end else begin
      unique case (state)
        S_RESET: state <= S_FETCH;

        // A redirect with no ack leaves req/addr untouched until the bus answers.
        S_FETCH: begin
          if (ctrl_pc_redirect) begin
            pc <= target;
            if (imem_ack) imem_addr <= target;
            else          state     <= S_DISCARD;
          end else if (imem_ack) begin
            if (ctrl_stall) begin
              hold_instr <= fetch_instr;
              hold_pc    <= imem_addr;
              hold_err   <= imem_error;
              state      <= S_HOLD;
            end else begin
              pc        <= pc + 32'd4;
              imem_addr <= pc + 32'd4;
            end
          end
        end

        S_HOLD: begin
          if (ctrl_pc_redirect) begin
            pc        <= target;
            imem_addr <= target;
            state     <= S_FETCH;
          end else if (!ctrl_stall) begin
            pc        <= hold_pc + 32'd4;
            imem_addr <= hold_pc + 32'd4;
            state     <= S_FETCH;
          end
        end

        // Newest redirect wins; the stale response is dropped when it lands.
        S_DISCARD: begin
          if (ctrl_pc_redirect) pc <= target;
          if (imem_ack) begin
            imem_addr <= ctrl_pc_redirect ? target : pc;
            state     <= S_FETCH;
          end
        end

        default: state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    imem_req       = 1'b0;
    if_instruction = 32'h0;
    if_pc          = 32'h0;
    if_exception   = 1'b0;
    if_stall_req   = 1'b0;
    unique case (state)
      S_RESET: if_stall_req = 1'b1;

      S_FETCH: begin
        imem_req     = 1'b1;
        if_stall_req = !imem_ack;
        if (imem_ack && !ctrl_pc_redirect) begin
          if_instruction = fetch_instr;
          if_pc          = imem_addr;
          if_exception   = imem_error;
        end
      end

      S_HOLD: begin
        if (!ctrl_pc_redirect) begin
          if_instruction = hold_instr;
          if_pc          = hold_pc;
          if_exception   = hold_err;
        end
      end

      S_DISCARD: begin
        imem_req     = 1'b1;
        if_stall_req = 1'b1;
      end

      default: if_stall_req = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_elbeth_fetch_unit.sv
// Bench for elbeth_fetch_unit: directed vector table, hand-written corner
// sequences, then random traffic checked against a transaction-level model.
module tb_elbeth_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic lo = 1'b0;
  localparam logic hi = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_stall;
  logic        ctrl_pc_redirect;
  logic [31:0] ctrl_pc_target;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        imem_error;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        if_exception;
  logic        if_stall_req;

  int n_cmp = 0;
  int n_err = 0;

  elbeth_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk(clk),
    .rst(rst),
    .ctrl_stall(ctrl_stall),
    .ctrl_pc_redirect(ctrl_pc_redirect),
    .ctrl_pc_target(ctrl_pc_target),
    .imem_addr(imem_addr),
    .imem_req(imem_req),
    .imem_rdata(imem_rdata),
    .imem_ack(imem_ack),
    .imem_error(imem_error),
    .if_instruction(if_instruction),
    .if_pc(if_pc),
    .if_exception(if_exception),
    .if_stall_req(if_stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_exc;
    logic        e_sr;
  } vec_t;

  vec_t tbl[$];
  vec_t hand[$];

  function automatic vec_t mkv(
    input logic rst_i, input logic stall_i, input logic redir_i, input logic [31:0] tgt_i,
    input logic ack_i, input logic [31:0] rdata_i, input logic err_i,
    input logic e_req_i, input logic [31:0] e_addr_i, input logic [31:0] e_instr_i,
    input logic [31:0] e_pc_i, input logic e_exc_i, input logic e_sr_i);
    vec_t v;
    v.rst = rst_i;  v.stall = stall_i;  v.redir = redir_i;  v.tgt = tgt_i;
    v.ack = ack_i;  v.rdata = rdata_i;  v.err = err_i;
    v.e_req = e_req_i;  v.e_addr = e_addr_i;  v.e_instr = e_instr_i;
    v.e_pc = e_pc_i;  v.e_exc = e_exc_i;  v.e_sr = e_sr_i;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic st, input logic rd,
                               input logic [31:0] tg, input logic ak,
                               input logic [31:0] dat, input logic er);
    rst              = r;
    ctrl_stall       = st;
    ctrl_pc_redirect = rd;
    ctrl_pc_target   = tg;
    imem_ack         = ak;
    imem_rdata       = dat;
    imem_error       = er;
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic [31:0] e_instr, input logic [31:0] e_pc,
                             input logic e_exc, input logic e_sr);
    check32({tag, ".imem_req"},       {31'b0, imem_req},     {31'b0, e_req});
    check32({tag, ".imem_addr"},      imem_addr,             e_addr);
    check32({tag, ".if_instruction"}, if_instruction,        e_instr);
    check32({tag, ".if_pc"},          if_pc,                 e_pc);
    check32({tag, ".if_exception"},   {31'b0, if_exception}, {31'b0, e_exc});
    check32({tag, ".if_stall_req"},   {31'b0, if_stall_req}, {31'b0, e_sr});
  endtask

  task automatic runVec(input vec_t v, input string tag);
    @(negedge clk);
    applyStimulus(v.rst, v.stall, v.redir, v.tgt, v.ack, v.rdata, v.err);
    #1;
    checkOutput(tag, v.e_req, v.e_addr, v.e_instr, v.e_pc, v.e_exc, v.e_sr);
  endtask

  // Reference model: tracks the outstanding request, whether it is stale,
  // and any instruction parked while the pipeline is stalled.
  logic        m_in_reset;
  logic        m_stale;
  logic        m_held;
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic [31:0] m_h_instr;
  logic [31:0] m_h_pc;
  logic        m_h_err;

  function automatic logic model_req();
    return !m_in_reset && !m_held;
  endfunction

  task automatic modelStep(input logic r, input logic st, input logic rd,
                           input logic [31:0] tg_raw, input logic ak,
                           input logic [31:0] dat, input logic er, input string tag);
    logic [31:0] tg;
    logic        e_req, e_exc, e_sr;
    logic [31:0] e_instr, e_pc;
    logic        deliver;
    tg      = tg_raw & 32'hFFFF_FFFC;
    e_req   = model_req();
    e_instr = 32'h0;
    e_pc    = 32'h0;
    e_exc   = 1'b0;
    if (m_in_reset) begin
      e_sr = 1'b1;
    end else if (m_held) begin
      e_sr = 1'b0;
      if (!rd) begin
        e_instr = m_h_instr;
        e_pc    = m_h_pc;
        e_exc   = m_h_err;
      end
    end else begin
      e_sr    = m_stale ? 1'b1 : !ak;
      deliver = ak && !m_stale && !rd;
      if (deliver) begin
        e_instr = er ? 32'h0 : dat;
        e_pc    = m_addr;
        e_exc   = er;
      end
    end
    checkOutput(tag, e_req, m_addr, e_instr, e_pc, e_exc, e_sr);

    if (r) begin
      m_in_reset = 1'b1;
      m_stale    = 1'b0;
      m_held     = 1'b0;
      m_pc       = RV;
      m_addr     = RV;
    end else if (m_in_reset) begin
      m_in_reset = 1'b0;
    end else if (m_held) begin
      if (rd) begin
        m_pc = tg;  m_addr = tg;  m_held = 1'b0;
      end else if (!st) begin
        m_pc = m_h_pc + 32'd4;  m_addr = m_pc;  m_held = 1'b0;
      end
    end else if (m_stale) begin
      if (rd) m_pc = tg;
      if (ak) begin
        m_addr  = m_pc;
        m_stale = 1'b0;
      end
    end else if (rd) begin
      m_pc = tg;
      if (ak) m_addr = tg;
      else    m_stale = 1'b1;
    end else if (ak) begin
      if (st) begin
        m_held    = 1'b1;
        m_h_instr = er ? 32'h0 : dat;
        m_h_pc    = m_addr;
        m_h_err   = er;
      end else begin
        m_pc   = m_pc + 32'd4;
        m_addr = m_pc;
      end
    end
  endtask

  initial begin
    applyStimulus(hi, lo, lo, 32'h0, lo, 32'h0, lo);
    repeat (2) @(posedge clk);

    // Reset, zero-wait fetches, stall/hold, redirects, error, wrap, reset in discard.
    tbl.push_back(mkv(hi,lo,lo,32'h0,lo,32'h0,lo,               lo,32'h0,32'h0,32'h0,lo,hi));
    tbl.push_back(mkv(lo,lo,lo,32'h0,lo,32'h0,lo,               lo,32'h0,32'h0,32'h0,lo,hi));
    tbl.push_back(mkv(lo,lo,lo,32'h0,hi,32'h13,lo,              hi,32'h0,32'h13,32'h0,lo,lo));
    tbl.push_back(mkv(lo,lo,lo,32'h0,hi,32'h13,lo,              hi,32'h4,32'h13,32'h4,lo,lo));
    tbl.push_back(mkv(lo,hi,lo,32'h0,hi,32'hAAAA_0008,lo,       hi,32'h8,32'hAAAA_0008,32'h8,lo,lo));
    tbl.push_back(mkv(lo,hi,lo,32'h0,lo,32'h0,lo,               lo,32'h8,32'hAAAA_0008,32'h8,lo,lo));
    tbl.push_back(mkv(lo,hi,lo,32'h0,lo,32'h0,lo,               lo,32'h8,32'hAAAA_0008,32'h8,lo,lo));
    tbl.push_back(mkv(lo,lo,lo,32'h0,lo,32'h0,lo,               lo,32'h8,32'hAAAA_0008,32'h8,lo,lo));
    tbl.push_back(mkv(lo,lo,lo,32'h0,lo,32'hDEAD_BEEF,lo,       hi,32'hC,32'h0,32'h0,lo,hi));
    tbl.push_back(mkv(lo,lo,lo,32'h0,hi,32'h33,lo,              hi,32'hC,32'h33,32'hC,lo,lo));
    tbl.push_back(mkv(lo,lo,hi,32'h100,lo,32'h0,lo,             hi,32'h10,32'h0,32'h0,lo,hi));
    tbl.push_back(mkv(lo,lo,lo,32'h0,lo,32'h0,lo,               hi,32'h10,32'h0,32'h0,lo,hi));
    tbl.push_back(mkv(lo,lo,lo,32'h0,hi,32'hDEAD,lo,            hi,32'h10,32'h0,32'h0,lo,hi));
    tbl.push_back(mkv(lo,lo,lo,32'h0,hi,32'h0100_0013,lo,       hi,32'h100,32'h0100_0013,32'h100,lo,lo));
    tbl.push_back(mkv(lo,hi,hi,32'h23,hi,32'hBAD,lo,            hi,32'h104,32'h0,32'h0,lo,lo));
    tbl.push_back(mkv(lo,lo,lo,32'h0,hi,32'h20,hi,              hi,32'h20,32'h0,32'h20,hi,lo));
    tbl.push_back(mkv(lo,lo,hi,32'hFFFF_FFFF,lo,32'h0,lo,       hi,32'h24,32'h0,32'h0,lo,hi));
    tbl.push_back(mkv(lo,lo,lo,32'h0,hi,32'h0,lo,               hi,32'h24,32'h0,32'h0,lo,hi));
    tbl.push_back(mkv(lo,lo,lo,32'h0,hi,32'h77,lo,              hi,32'hFFFF_FFFC,32'h77,32'hFFFF_FFFC,lo,lo));
    tbl.push_back(mkv(lo,lo,lo,32'h0,lo,32'h0,lo,               hi,32'h0,32'h0,32'h0,lo,hi));
    tbl.push_back(mkv(lo,lo,hi,32'h40,lo,32'h0,lo,              hi,32'h0,32'h0,32'h0,lo,hi));
    tbl.push_back(mkv(hi,lo,lo,32'h0,lo,32'h0,lo,               hi,32'h0,32'h0,32'h0,lo,hi));
    tbl.push_back(mkv(lo,lo,lo,32'h0,lo,32'h0,lo,               lo,32'h0,32'h0,32'h0,lo,hi));
    tbl.push_back(mkv(lo,lo,lo,32'h0,hi,32'h13,lo,              hi,32'h0,32'h13,32'h0,lo,lo));
    foreach (tbl[i]) runVec(tbl[i], $sformatf("vec%0d", i));

    // Two wait states, then a redirect that lands while an instruction is held.
    hand.push_back(mkv(lo,lo,lo,32'h0,lo,32'h0,lo,              hi,32'h4,32'h0,32'h0,lo,hi));
    hand.push_back(mkv(lo,lo,lo,32'h0,lo,32'h0,lo,              hi,32'h4,32'h0,32'h0,lo,hi));
    hand.push_back(mkv(lo,lo,lo,32'h0,hi,32'h55,lo,             hi,32'h4,32'h55,32'h4,lo,lo));
    hand.push_back(mkv(lo,hi,lo,32'h0,hi,32'h66,lo,             hi,32'h8,32'h66,32'h8,lo,lo));
    hand.push_back(mkv(lo,hi,hi,32'h80,lo,32'h0,lo,             lo,32'h8,32'h0,32'h0,lo,lo));
    hand.push_back(mkv(lo,lo,lo,32'h0,hi,32'h88,lo,             hi,32'h80,32'h88,32'h80,lo,lo));
    foreach (hand[i]) runVec(hand[i], $sformatf("hand%0d", i));

    @(negedge clk);
    applyStimulus(hi, lo, lo, 32'h0, lo, 32'h0, lo);
    m_in_reset = 1'b1;  m_stale = 1'b0;  m_held = 1'b0;
    m_pc = RV;  m_addr = RV;
    m_h_instr = 32'h0;  m_h_pc = 32'h0;  m_h_err = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        r, st, rd, ak, er;
      logic [31:0] tg, dat;
      @(negedge clk);
      r  = ($urandom_range(0, 99) == 0);
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 7) == 0);
      tg = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      ak = model_req() && ($urandom_range(0, 2) != 0);
      dat = ak ? ((m_addr * 32'h9E37_79B1) ^ 32'h13) : $urandom;
      er = ak && ($urandom_range(0, 9) == 0);
      applyStimulus(r, st, rd, tg, ak, dat, er);
      #1;
      modelStep(r, st, rd, tg, ak, dat, er, $sformatf("rnd%0d", cyc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
